// File: rtl/green_centroid_pkg.sv
// Shared definitions for the green-blob centroid block: default widths,
// the found threshold and the centroid FSM state encoding.
package green_centroid_pkg;

    localparam int DEFAULT_X_W        = 10;
    localparam int DEFAULT_Y_W        = 10;
    localparam int DEFAULT_CNT_W      = 19;
    localparam int DEFAULT_SUM_W      = 29;
    localparam int DEFAULT_MIN_PIXELS = 64;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CHECK   = 3'd1,
        DIV_X   = 3'd2,
        DIV_Y   = 3'd3,
        PUBLISH = 3'd4
    } centroid_state_e;

endpackage

// File: rtl/green_centroid_seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock. done pulses
// N+1 cycles after start; a new start is accepted in the done cycle, so
// two divisions can run back to back.
module seq_divider #(
    parameter int N   = 29,
    parameter int D   = 19,
    parameter int Q_W = 10
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    input  logic           start_i,
    input  logic [N-1:0]   dividend_i,
    input  logic [D-1:0]   divisor_i,
    output logic           busy_o,
    output logic           done_o,
    output logic [Q_W-1:0] quotient_o
);

    localparam int CW = $clog2(N + 1);

    logic [N-1:0]  quot_q;
    logic [D-1:0]  rem_q;
    logic [D-1:0]  divisor_q;
    logic [CW-1:0] count_q;
    logic          busy_q;
    logic          done_q;

    logic [D:0]    remShift;
    logic [D-1:0]  remSub;
    logic          fits;

    // The remainder is always below the divisor, so the shifted value fits
    // in D+1 bits and the difference fits back into D bits.
    assign remShift = {rem_q, quot_q[N-1]};
    assign fits     = remShift >= {1'b0, divisor_q};
    assign remSub   = remShift[D-1:0] - divisor_q;

    // Load operands on start, then shift one dividend bit into the
    // remainder per cycle, replacing it with the quotient bit.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            quot_q    <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
            count_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                quot_q    <= dividend_i;
                rem_q     <= '0;
                divisor_q <= divisor_i;
                count_q   <= CW'(N);
                busy_q    <= 1'b1;
            end else if (busy_q) begin
                rem_q   <= fits ? remSub : remShift[D-1:0];
                quot_q  <= {quot_q[N-2:0], fits};
                count_q <= count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign quotient_o = quot_q[Q_W-1:0];

endmodule

// File: rtl/green_centroid.sv
// Accumulates green-pixel count and coordinate sums over a frame and, at
// the rising edge of vsync, divides them to publish the blob centroid.
module green_centroid
    import green_centroid_pkg::*;
#(
    parameter int X_W        = DEFAULT_X_W,
    parameter int Y_W        = DEFAULT_Y_W,
    parameter int CNT_W      = DEFAULT_CNT_W,
    parameter int SUM_W      = DEFAULT_SUM_W,
    parameter int MIN_PIXELS = DEFAULT_MIN_PIXELS
) (
    input  logic             PCLK,
    input  logic             rst_n,
    input  logic             pix_valid,
    input  logic             eh_verde,
    input  logic [X_W-1:0]   x,
    input  logic [Y_W-1:0]   y,
    input  logic             vsync,
    output logic [X_W-1:0]   cx,
    output logic [Y_W-1:0]   cy,
    output logic [CNT_W-1:0] blob_count,
    output logic             found,
    output logic             result_valid,
    output logic             busy,
    output logic             overrun
);

    localparam int Q_W = (X_W > Y_W) ? X_W : Y_W;

    centroid_state_e state_q;

    logic             vsync_q;
    logic             frameEnd;
    logic             pixelHit;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SUM_W-1:0] sx_q, sx_d;
    logic [SUM_W-1:0] sy_q, sy_d;
    logic [CNT_W:0]   cntSum;
    logic [SUM_W:0]   sxSum;
    logic [SUM_W:0]   sySum;

    logic [CNT_W-1:0] snapCnt_q;
    logic [SUM_W-1:0] snapSx_q;
    logic [SUM_W-1:0] snapSy_q;

    logic             startX_q;
    logic [X_W-1:0]   qx_q;
    logic [X_W-1:0]   cx_q;
    logic [Y_W-1:0]   cy_q;
    logic [CNT_W-1:0] blobCount_q;
    logic             found_q;
    logic             resultValid_q;
    logic             overrun_q;

    logic             divStart;
    logic [SUM_W-1:0] divDividend;
    logic             divBusy;
    logic             divDone;
    logic [Q_W-1:0]   divQuot;

    assign frameEnd = vsync & ~vsync_q;
    assign pixelHit = pix_valid & eh_verde;

    // One extra bit on each sum exposes the carry used to saturate.
    assign cntSum = {1'b0, cnt_q} + (CNT_W+1)'(1);
    assign sxSum  = {1'b0, sx_q} + (SUM_W+1)'(x);
    assign sySum  = {1'b0, sy_q} + (SUM_W+1)'(y);

    // Next accumulator values include the current pixel, so the snapshot
    // taken on the frame-end cycle sees a pixel arriving in that same cycle.
    always_comb begin
        cnt_d = cnt_q;
        sx_d  = sx_q;
        sy_d  = sy_q;
        if (pixelHit) begin
            cnt_d = cntSum[CNT_W] ? '1 : cntSum[CNT_W-1:0];
            sx_d  = sxSum[SUM_W]  ? '1 : sxSum[SUM_W-1:0];
            sy_d  = sySum[SUM_W]  ? '1 : sySum[SUM_W-1:0];
        end
    end

    // Frame accumulators restart from zero after every frame end, whether
    // or not that frame is actually processed.
    always_ff @(posedge PCLK or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q <= 1'b0;
            cnt_q   <= '0;
            sx_q    <= '0;
            sy_q    <= '0;
        end else begin
            vsync_q <= vsync;
            if (frameEnd) begin
                cnt_q <= '0;
                sx_q  <= '0;
                sy_q  <= '0;
            end else begin
                cnt_q <= cnt_d;
                sx_q  <= sx_d;
                sy_q  <= sy_d;
            end
        end
    end

    // The x division is kicked off by a registered pulse on entering DIV_X;
    // the y division restarts the divider in the cycle x reports done.
    assign divStart    = startX_q | ((state_q == DIV_X) & divDone);
    assign divDividend = startX_q ? snapSx_q : snapSy_q;

    seq_divider #(
        .N   (SUM_W),
        .D   (CNT_W),
        .Q_W (Q_W)
    ) u_divider (
        .clk_i      (PCLK),
        .rst_n_i    (rst_n),
        .start_i    (divStart),
        .dividend_i (divDividend),
        .divisor_i  (snapCnt_q),
        .busy_o     (divBusy),
        .done_o     (divDone),
        .quotient_o (divQuot)
    );

    // Centroid FSM: snapshots the frame, divides, and publishes registered results.
    always_ff @(posedge PCLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            snapCnt_q     <= '0;
            snapSx_q      <= '0;
            snapSy_q      <= '0;
            startX_q      <= 1'b0;
            qx_q          <= '0;
            cx_q          <= '0;
            cy_q          <= '0;
            blobCount_q   <= '0;
            found_q       <= 1'b0;
            resultValid_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            startX_q      <= 1'b0;
            resultValid_q <= 1'b0;

            if (frameEnd) begin
                if (state_q == IDLE) begin
                    snapCnt_q <= cnt_d;
                    snapSx_q  <= sx_d;
                    snapSy_q  <= sy_d;
                end else begin
                    overrun_q <= 1'b1;
                end
            end

            case (state_q)
                IDLE: begin
                    if (frameEnd) begin
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    if (snapCnt_q < CNT_W'(MIN_PIXELS)) begin
                        blobCount_q   <= snapCnt_q;
                        found_q       <= 1'b0;
                        resultValid_q <= 1'b1;
                        state_q       <= PUBLISH;
                    end else begin
                        startX_q <= 1'b1;
                        state_q  <= DIV_X;
                    end
                end
                DIV_X: begin
                    if (divDone) begin
                        qx_q    <= divQuot[X_W-1:0];
                        state_q <= DIV_Y;
                    end
                end
                DIV_Y: begin
                    if (divDone) begin
                        cx_q          <= qx_q;
                        cy_q          <= divQuot[Y_W-1:0];
                        blobCount_q   <= snapCnt_q;
                        found_q       <= 1'b1;
                        resultValid_q <= 1'b1;
                        state_q       <= PUBLISH;
                    end
                end
                PUBLISH: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cx           = cx_q;
    assign cy           = cy_q;
    assign blob_count   = blobCount_q;
    assign found        = found_q;
    assign result_valid = resultValid_q;
    assign busy         = (state_q != IDLE) | divBusy;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_green_centroid.sv
// Directed bench for green_centroid: hand-computed centroids, latencies,
// overrun handling, frame-boundary pixels and reset during division.
module tb_green_centroid;

    logic        PCLK = 1'b0;
    logic        rst_n = 1'b0;
    logic        pix_valid = 1'b0;
    logic        eh_verde = 1'b0;
    logic [9:0]  x = '0;
    logic [9:0]  y = '0;
    logic        vsync = 1'b0;
    logic [9:0]  cx;
    logic [9:0]  cy;
    logic [18:0] blob_count;
    logic        found;
    logic        result_valid;
    logic        busy;
    logic        overrun;

    int assertions = 0;
    int failures   = 0;
    int cyc;
    int extra;

    green_centroid dut (
        .PCLK         (PCLK),
        .rst_n        (rst_n),
        .pix_valid    (pix_valid),
        .eh_verde     (eh_verde),
        .x            (x),
        .y            (y),
        .vsync        (vsync),
        .cx           (cx),
        .cy           (cy),
        .blob_count   (blob_count),
        .found        (found),
        .result_valid (result_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    // Free-running pixel clock.
    always #5 PCLK = ~PCLK;

    task automatic tick;
        @(posedge PCLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertions++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int n, input logic pv, input logic g,
                                 input logic [9:0] px, input logic [9:0] py);
        pix_valid = pv;
        eh_verde  = g;
        x         = px;
        y         = py;
        repeat (n) tick();
        pix_valid = 1'b0;
        eh_verde  = 1'b0;
    endtask

    task automatic waitResult(input int maxCycles, output int seen);
        seen = -1;
        for (int i = 1; i <= maxCycles; i++) begin
            tick();
            vsync = 1'b0;
            if (result_valid === 1'b1) begin
                seen = i;
                break;
            end
        end
    endtask

    task automatic frameAndCheck(input string name, input int expLat, input int expCx,
                                 input int expCy, input int expCnt, input int expFound);
        int lat;
        vsync = 1'b1;
        waitResult(200, lat);
        checkOutput({name, " latency"}, 32'(lat), 32'(expLat));
        checkOutput({name, " cx"}, 32'(cx), 32'(expCx));
        checkOutput({name, " cy"}, 32'(cy), 32'(expCy));
        checkOutput({name, " blob_count"}, 32'(blob_count), 32'(expCnt));
        checkOutput({name, " found"}, 32'(found), 32'(expFound));
        tick();
        checkOutput({name, " result_valid pulse width"}, 32'(result_valid), 32'd0);
        checkOutput({name, " busy after publish"}, 32'(busy), 32'd0);
    endtask

    initial begin
        $display("[TB] green_centroid directed test start");

        // Reset state
        repeat (3) tick();
        checkOutput("reset cx", 32'(cx), 32'd0);
        checkOutput("reset cy", 32'(cy), 32'd0);
        checkOutput("reset blob_count", 32'(blob_count), 32'd0);
        checkOutput("reset found", 32'(found), 32'd0);
        checkOutput("reset result_valid", 32'(result_valid), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset overrun", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        tick();

        // 100 pixels at (10,20)
        applyStimulus(100, 1'b1, 1'b1, 10'd10, 10'd20);
        frameAndCheck("single point", 63, 10, 20, 100, 1);

        // Extremes of the frame plus ignored pixels
        applyStimulus(50, 1'b1, 1'b1, 10'd0, 10'd0);
        applyStimulus(10, 1'b0, 1'b1, 10'd600, 10'd400);
        applyStimulus(50, 1'b1, 1'b1, 10'd639, 10'd479);
        applyStimulus(10, 1'b1, 1'b0, 10'd600, 10'd400);
        frameAndCheck("corners", 63, 319, 239, 100, 1);

        // Below threshold: old centroid kept
        applyStimulus(63, 1'b1, 1'b1, 10'd5, 10'd5);
        frameAndCheck("below threshold", 2, 319, 239, 63, 0);
        checkOutput("no overrun yet", 32'(overrun), 32'd0);

        // Second frame end 10 cycles after the first
        applyStimulus(100, 1'b1, 1'b1, 10'd100, 10'd200);
        vsync = 1'b1;
        tick();
        vsync     = 1'b0;
        pix_valid = 1'b1;
        eh_verde  = 1'b1;
        x         = 10'd400;
        y         = 10'd400;
        repeat (9) tick();
        pix_valid = 1'b0;
        eh_verde  = 1'b0;
        vsync     = 1'b1;
        checkOutput("busy at second edge", 32'(busy), 32'd1);
        tick();
        vsync = 1'b0;
        checkOutput("overrun set", 32'(overrun), 32'd1);
        waitResult(200, cyc);
        checkOutput("overrun first latency", 32'(cyc), 32'd52);
        checkOutput("overrun cx", 32'(cx), 32'd100);
        checkOutput("overrun cy", 32'(cy), 32'd200);
        checkOutput("overrun blob_count", 32'(blob_count), 32'd100);
        extra = 0;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (result_valid === 1'b1) extra++;
        end
        checkOutput("dropped frame pulses", 32'(extra), 32'd0);
        applyStimulus(64, 1'b1, 1'b1, 10'd20, 10'd30);
        frameAndCheck("after overrun", 63, 20, 30, 64, 1);
        checkOutput("overrun sticky", 32'(overrun), 32'd1);

        // Pixels at the frame boundary
        applyStimulus(63, 1'b1, 1'b1, 10'd8, 10'd8);
        pix_valid = 1'b1;
        eh_verde  = 1'b1;
        vsync     = 1'b1;
        tick();
        vsync = 1'b0;
        x     = 10'd2;
        y     = 10'd2;
        tick();
        pix_valid = 1'b0;
        eh_verde  = 1'b0;
        waitResult(200, cyc);
        checkOutput("boundary latency", 32'(cyc), 32'd61);
        checkOutput("boundary cx", 32'(cx), 32'd8);
        checkOutput("boundary cy", 32'(cy), 32'd8);
        checkOutput("boundary blob_count", 32'(blob_count), 32'd64);
        checkOutput("boundary found", 32'(found), 32'd1);
        tick();
        applyStimulus(63, 1'b1, 1'b1, 10'd2, 10'd2);
        frameAndCheck("next frame", 63, 2, 2, 64, 1);

        // Reset during the x division
        applyStimulus(100, 1'b1, 1'b1, 10'd50, 10'd60);
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        repeat (9) tick();
        checkOutput("busy in division", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort cx", 32'(cx), 32'd0);
        checkOutput("abort cy", 32'(cy), 32'd0);
        checkOutput("abort blob_count", 32'(blob_count), 32'd0);
        checkOutput("abort found", 32'(found), 32'd0);
        checkOutput("abort result_valid", 32'(result_valid), 32'd0);
        checkOutput("abort busy", 32'(busy), 32'd0);
        checkOutput("abort overrun", 32'(overrun), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        extra = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (result_valid === 1'b1) extra++;
        end
        checkOutput("pulses after abort", 32'(extra), 32'd0);
        applyStimulus(100, 1'b1, 1'b1, 10'd7, 10'd9);
        frameAndCheck("after abort", 63, 7, 9, 100, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
